// File: rtl/prog_loader_if.sv
// prog_loader_if: byte stream in, program-memory write port out.
interface prog_loader_if #(
    parameter int PC_WIDTH = 8,
    parameter int PROGRAM_DataWidth = 16,
    parameter int ByteWidth = 8
);
    logic [ByteWidth-1:0] byte_in;
    logic byte_valid;
    logic byte_ready;
    logic prog_wr_en;
    logic [PC_WIDTH-1:0] prog_wr_adr;
    logic [PROGRAM_DataWidth-1:0] prog_wr_data;
    modport master (
        output byte_in, byte_valid,
        input byte_ready, prog_wr_en, prog_wr_adr, prog_wr_data
    );
    modport slave (
        input byte_in, byte_valid,
        output byte_ready, prog_wr_en, prog_wr_adr, prog_wr_data
    );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: assembles a length-prefixed, checksummed byte stream into program-memory words.
module prog_loader #(
    parameter int PC_WIDTH = 8,
    parameter int PROGRAM_DataWidth = 16,
    parameter int ByteWidth = 8,
    parameter int NumOpCodeBits = 5
) (
    input logic clk,
    input logic rst_n,
    input logic start,
    prog_loader_if.slave bus,
    output logic cpu_hold,
    output logic done,
    output logic error,
    output logic bad_op
);
    typedef enum logic [2:0] {IDLE, LEN, HI, LO, WRITE, CSUM, DONE, ERR} state_t;
    state_t st, nxt;
    logic [ByteWidth-1:0] hi, cnt, sum, sum_nxt;
    logic [NumOpCodeBits-1:0] op;
    logic fire, start_ok, reserved;
    assign fire = bus.byte_valid && bus.byte_ready;
    always_comb begin
        sum_nxt = sum + bus.byte_in;
        op = bus.byte_in[ByteWidth-1 -: NumOpCodeBits];
        reserved = (op >= 5'h0A && op <= 5'h0F) || op >= 5'h16;
        start_ok = start && (st == IDLE || st == DONE || st == ERR);
        nxt = st;
        case (st)
            IDLE, DONE, ERR: nxt = start ? LEN : st;
            LEN: nxt = fire ? (bus.byte_in == '0 ? CSUM : HI) : st;
            HI: nxt = fire ? LO : st;
            LO: nxt = fire ? WRITE : st;
            WRITE: nxt = cnt > ByteWidth'(1) ? HI : CSUM;
            CSUM: nxt = fire ? (sum_nxt == '0 ? DONE : ERR) : st;
            default: nxt = IDLE;
        endcase
    end
    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= IDLE;
            hi <= '0;
            cnt <= '0;
            sum <= '0;
            bus.byte_ready <= 1'b0;
            bus.prog_wr_en <= 1'b0;
            bus.prog_wr_adr <= '0;
            bus.prog_wr_data <= '0;
            cpu_hold <= 1'b0;
            done <= 1'b0;
            error <= 1'b0;
            bad_op <= 1'b0;
        end else begin
            st <= nxt;
            bus.byte_ready <= nxt == LEN || nxt == HI || nxt == LO || nxt == CSUM;
            bus.prog_wr_en <= nxt == WRITE;
            if (start_ok) begin
                bus.prog_wr_adr <= '0;
                sum <= '0;
                done <= 1'b0;
                error <= 1'b0;
                bad_op <= 1'b0;
                cpu_hold <= 1'b1;
            end
            if (fire) sum <= sum_nxt;
            if (fire && st == LEN) cnt <= bus.byte_in;
            if (fire && st == HI) begin
                hi <= bus.byte_in;
                if (reserved) bad_op <= 1'b1;
            end
            if (fire && st == LO) bus.prog_wr_data <= PROGRAM_DataWidth'({hi, bus.byte_in});
            if (st == WRITE) begin
                bus.prog_wr_adr <= bus.prog_wr_adr + PC_WIDTH'(1);
                cnt <= cnt - ByteWidth'(1);
            end
            if (fire && st == CSUM) begin
                done <= sum_nxt == '0;
                error <= sum_nxt != '0;
                cpu_hold <= sum_nxt != '0;
            end
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized stream loads checked by a write scoreboard and a stream-level model.
module tb_prog_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic cpu_hold, done, error, bad_op;
    int checks = 0;
    int failures = 0;
    logic [23:0] sb[$];
    logic [23:0] exp_wr;
    logic [7:0] bq[$];

    prog_loader_if #(.PC_WIDTH(8)) bus();

    prog_loader dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .bus(bus.slave),
        .cpu_hold(cpu_hold),
        .done(done),
        .error(error),
        .bad_op(bad_op)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Every write strobe must match the oldest expected {adr, data}.
    always @(negedge clk) begin
        if (rst_n && bus.prog_wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wr_unexpected actual=%0h@%0h required=none", bus.prog_wr_data, bus.prog_wr_adr);
            end else begin
                exp_wr = sb.pop_front();
                check("wr_adr_data", {8'h0, bus.prog_wr_adr, bus.prog_wr_data}, {8'h0, exp_wr});
            end
        end
    end

    function automatic bit reserved_op(input logic [7:0] h);
        logic [4:0] o;
        o = h[7:3];
        return o inside {[5'd10:5'd15], [5'd22:5'd31]};
    endfunction

    task automatic check_reset_values();
        check("rst_byte_ready", bus.byte_ready, 0);
        check("rst_wr_en", bus.prog_wr_en, 0);
        check("rst_cpu_hold", cpu_hold, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_bad_op", bad_op, 0);
        check("rst_wr_adr", bus.prog_wr_adr, 0);
        check("rst_wr_data", bus.prog_wr_data, 0);
    endtask

    task automatic send(input logic [7:0] b, input int gmin, input int gmax, input bit ms);
        int g;
        int guard;
        g = $urandom_range(gmax, gmin);
        repeat (g) begin
            @(negedge clk);
            bus.byte_valid = 1'b0;
        end
        @(negedge clk);
        bus.byte_in = b;
        bus.byte_valid = 1'b1;
        start = ms;
        guard = 0;
        while (bus.byte_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            start = 1'b0;
            guard++;
        end
        if (guard >= 100) begin
            checks++;
            failures++;
            $display("FAIL byte_timeout actual=not_ready required=ready byte=%0h", b);
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Plays bq as one session; abort > 0 resets after that many bytes.
    task automatic run(input int gmin, input int gmax, input bit ms, input int abort);
        int n;
        int limit;
        int guard;
        logic [7:0] s;
        bit bad;
        n = int'(bq[0]);
        limit = abort > 0 ? abort : bq.size();
        s = 8'h0;
        bad = 1'b0;
        foreach (bq[k]) s = s + bq[k];
        for (int i = 0; i < n; i++) begin
            if (reserved_op(bq[1 + 2 * i])) bad = 1'b1;
            if (2 + 2 * i < limit) sb.push_back({i[7:0], bq[1 + 2 * i], bq[2 + 2 * i]});
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_cpu_hold", cpu_hold, 1);
        check("start_byte_ready", bus.byte_ready, 1);
        check("start_flags", {done, error, bad_op}, 0);
        for (int k = 0; k < limit; k++) send(bq[k], gmin, gmax, ms && k == 3);
        @(negedge clk);
        bus.byte_valid = 1'b0;
        if (abort > 0) begin
            rst_n = 1'b0;
            #1 check_reset_values();
            @(negedge clk);
            rst_n = 1'b1;
            check("abort_writes_left", sb.size(), 0);
            sb.delete();
            return;
        end
        guard = 0;
        while (!(done || error) && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("end_done", done, s == 8'h0);
        check("end_error", error, s != 8'h0);
        check("end_bad_op", bad_op, bad);
        check("end_cpu_hold", cpu_hold, s != 8'h0);
        check("end_byte_ready", bus.byte_ready, 0);
        check("end_writes_left", sb.size(), 0);
        sb.delete();
    endtask

    task automatic build_random(input int n, input bit corrupt);
        logic [7:0] s;
        logic [7:0] b;
        bq.delete();
        bq.push_back(n[7:0]);
        s = n[7:0];
        for (int i = 0; i < 2 * n; i++) begin
            b = 8'($urandom);
            bq.push_back(b);
            s = s + b;
        end
        bq.push_back(8'(-s) + (corrupt ? 8'($urandom_range(255, 1)) : 8'h0));
    endtask

    initial begin
        bus.byte_in = 8'h0;
        bus.byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        bq = '{8'h02, 8'h09, 8'h10, 8'h80, 8'h3F, 8'h26};
        run(0, 0, 0, 0);
        bq = '{8'h02, 8'h09, 8'h10, 8'h80, 8'h3F, 8'h27};
        run(0, 0, 0, 0);
        bq = '{8'h02, 8'h09, 8'h10, 8'h80, 8'h3F, 8'h26};
        run(1, 1, 0, 0);
        run(0, 2, 1, 0);
        bq = '{8'h01, 8'h50, 8'h00, 8'hAF};
        run(0, 0, 0, 0);
        bq = '{8'h00, 8'h00};
        run(0, 0, 0, 0);
        bq = '{8'h02, 8'h09, 8'h10, 8'h80, 8'h3F, 8'h26};
        run(0, 0, 0, 4);
        run(0, 0, 0, 0);
        build_random(255, 0);
        run(0, 0, 0, 0);
        for (int t = 0; t < 25; t++) begin
            build_random($urandom_range(6, 0), $urandom_range(3, 0) == 0);
            run(0, $urandom_range(2, 0), $urandom_range(1, 0) == 1, 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
# prog_loader

Program-memory loader for the 8-bit core: receives a length-prefixed, checksummed byte stream over a valid/ready interface and assembles it into 16-bit instruction words. It writes each word to program memory at consecutive addresses starting at 0. It is the writer side of the instruction path that the decoder reads, and it holds the core in reset (`cpu_hold`) while a load is in progress.

## Interface
Parameters:
- `PC_WIDTH`, 8, program address width.
- `PROGRAM_DataWidth`, 16, instruction word width; fixed at 2 bytes.
- `ByteWidth`, 8, stream byte width.
- `NumOpCodeBits`, 5, opcode field width, occupying instruction bits [15:11].

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse that begins a load session.
- `byte_in`  in  8  stream data.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `prog_wr_en`  out  1  one-cycle program-memory write strobe.
- `prog_wr_adr`  out  PC_WIDTH  write address.
- `prog_wr_data`  out  16  write data.
- `cpu_hold`  out  1  keeps the core in reset while high.
- `done`  out  1  load completed with a good checksum; sticky.
- `error`  out  1  checksum mismatch; sticky.
- `bad_op`  out  1  at least one loaded word carries a reserved opcode; sticky.

## Operation
- Stream format: length byte N (0..255), then 2N bytes (per word: high byte, then low byte), then one checksum byte C.
- Checksum rule: the 8-bit wrap-around sum of N, all data bytes, and C must equal 0x00.
- A byte is transferred on a cycle where `byte_valid && byte_ready` is true.
- States:
  - IDLE: `byte_ready` = 0. `start` → LEN.
  - LEN: `byte_ready` = 1. Accept N. N = 0 → CSUM; otherwise → HI.
  - HI: `byte_ready` = 1. Accept the high byte and latch it. If `byte_in[7:3]` is reserved (0_1010..0_1111 or 1_0110..1_1111), set `bad_op`. → LO.
  - LO: `byte_ready` = 1. Accept the low byte. → WRITE.
  - WRITE: `byte_ready` = 0. `prog_wr_en` = 1 with `prog_wr_data` = {hi, lo}. On exit the address increments and the remaining-word count decrements. → HI if words remain, else → CSUM.
  - CSUM: `byte_ready` = 1. Accept C. Running sum == 0 → DONE; otherwise → ERR.
  - DONE: `done` = 1, `cpu_hold` = 0. `start` → LEN.
  - ERR: `error` = 1, `cpu_hold` stays 1. `start` → LEN.
- On `start` accepted (from IDLE, DONE or ERR):
  - Clear `prog_wr_adr`, the running sum, `done`, `error` and `bad_op`.
  - Set `cpu_hold`.
- `start` while in LEN/HI/LO/WRITE/CSUM is ignored.
- `bad_op` does not cause ERR. It is reported alongside `done`.
- Addresses never wrap: at most 255 words, written to addresses 0..N-1.

## Timing
- Reset values:
  - State IDLE.
  - `byte_ready`, `prog_wr_en`, `cpu_hold`, `done`, `error`, `bad_op` all 0.
  - `prog_wr_adr` = 0, `prog_wr_data` = 0.
- All outputs are registered.
- `cpu_hold` and `byte_ready` go high on the first edge after the `start` pulse (LEN).
- Best-case throughput is one word per 3 cycles (HI, LO, WRITE).
- `prog_wr_adr` and `prog_wr_data` are stable during the `prog_wr_en` cycle.
- A byte offered during WRITE or IDLE is not consumed; the source must hold it until `byte_ready`.
- Gaps in `byte_valid` stall the FSM in its current state with no side effects.
- `done`/`error` assert on the edge after C is accepted. `cpu_hold` drops on that same edge for DONE.
- Reset mid-load: everything returns immediately to reset values. The partially written program is left as is; no further writes occur.

## Test plan
- Good load: start, then stream 02 09 10 80 3F 26 → writes 0x0910@0x00 and 0x803F@0x01, one `prog_wr_en` each; `done` = 1, `error` = 0, `bad_op` = 0, `cpu_hold` 1→0.
- Bad checksum: same stream with last byte 27 → both writes occur; `error` = 1, `done` = 0, `cpu_hold` stays 1 until the next start.
- Reserved opcode: stream 01 50 00 AF → write 0x5000@0x00; `bad_op` = 1, `done` = 1.
- Empty program: stream 00 00 → no `prog_wr_en`; `done` = 1 two bytes after start.
- Backpressure and stall:
  - `byte_valid` toggles every other cycle → identical writes to the good-load case.
  - A byte held through WRITE is accepted exactly once.
  - `start` pulsed mid-load is ignored.
- Reset mid-load: drop `rst_n` after the third data byte → all outputs at reset values; a subsequent full good load succeeds from address 0x00.
